// File: rtl/axis_serdes_pkg.sv
// axis_serdes_pkg: shared types and default widths for the SERDES TX byte path.
package axis_serdes_pkg;

    localparam int IN_BYTES_DEF = 4;
    localparam int BYTE_W_DEF   = 8;

    typedef struct packed {
        logic                    last;
        logic [BYTE_W_DEF-1:0]   data;
    } fifo_word_t;

    typedef enum logic {
        IDLE,
        UNPACK
    } state_t;

endpackage

// File: rtl/axis_fifo_packer_lsb_first_index.sv
// lsb_first_index: priority encoder returning the lowest set bit of a mask,
// plus a flag telling whether exactly one bit is set.
module lsb_first_index #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask_i,
    output logic [IW-1:0] idx_o,
    output logic          one_hot_o
);

    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--)
            if (mask_i[i]) idx_o = IW'(i);
    end

    assign one_hot_o = (mask_i != '0) && ((mask_i & (mask_i - 1'b1)) == '0);

endmodule

// File: rtl/axis_fifo_packer.sv
// axis_fifo_packer: unpacks AXI-Stream beats into single tagged bytes for the
// async FIFO write port, LSB byte first, one byte per cycle while not full.
module axis_fifo_packer
    import axis_serdes_pkg::*;
#(
    parameter int IN_BYTES = IN_BYTES_DEF,
    parameter int BYTE_W   = BYTE_W_DEF
) (
    input  logic                       i_wclk,
    input  logic                       i_rst_n,
    input  logic [IN_BYTES*BYTE_W-1:0] s_axis_tdata,
    input  logic [IN_BYTES-1:0]        s_axis_tkeep,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic                       o_wr,
    output logic [BYTE_W:0]            o_wdata,
    input  logic                       i_wfull,
    output logic                       o_busy,
    output logic [15:0]                o_frame_cnt,
    output logic                       o_err
);

    localparam int IW = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;

    state_t                     state_q, state_d;
    logic [IN_BYTES*BYTE_W-1:0] data_q, data_d;
    logic [IN_BYTES-1:0]        mask_q, mask_d;
    logic                       last_q, last_d;
    logic [15:0]                frame_cnt_q, frame_cnt_d;
    logic                       err_q, err_d;
    logic [IW-1:0]              idx;
    logic                       one_hot;
    logic                       final_wr;
    logic                       accept;

    lsb_first_index #(.N(IN_BYTES), .IW(IW)) u_idx (
        .mask_i    (mask_q),
        .idx_o     (idx),
        .one_hot_o (one_hot)
    );

    assign o_wr          = (state_q == UNPACK) && !i_wfull;
    assign final_wr      = o_wr && one_hot;
    // Ready on the last-byte cycle lets the next beat load with no bubble.
    assign s_axis_tready = (state_q == IDLE) || final_wr;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign o_wdata       = {last_q && one_hot, data_q[idx*BYTE_W +: BYTE_W]};
    assign o_busy        = (state_q == UNPACK);
    assign o_frame_cnt   = frame_cnt_q;
    assign o_err         = err_q;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        mask_d      = mask_q;
        last_d      = last_q;
        err_d       = err_q;
        frame_cnt_d = (final_wr && last_q) ? frame_cnt_q + 16'd1 : frame_cnt_q;
        if (o_wr) mask_d[idx] = 1'b0;
        if (final_wr) state_d = IDLE;
        if (accept && s_axis_tkeep != '0) begin
            state_d = UNPACK;
            data_d  = s_axis_tdata;
            mask_d  = s_axis_tkeep;
            last_d  = s_axis_tlast;
        end
        // An empty closing beat cannot carry the last flag into the FIFO.
        if (accept && s_axis_tkeep == '0 && s_axis_tlast) err_d = 1'b1;
    end

    always_ff @(posedge i_wclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            mask_q      <= '0;
            last_q      <= 1'b0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            last_q      <= last_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_axis_fifo_packer.sv
// tb_axis_fifo_packer: directed scenario tests for the AXIS-to-FIFO byte packer.
module tb_axis_fifo_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] tdata = '0;
    logic [3:0]  tkeep = '0;
    logic        tlast = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        wr;
    logic [8:0]  wdata;
    logic        wfull = 1'b0;
    logic        busy;
    logic [15:0] fcnt;
    logic        err;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    axis_fifo_packer dut (
        .i_wclk        (clk),
        .i_rst_n       (rst_n),
        .s_axis_tdata  (tdata),
        .s_axis_tkeep  (tkeep),
        .s_axis_tlast  (tlast),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .o_wr          (wr),
        .o_wdata       (wdata),
        .i_wfull       (wfull),
        .o_busy        (busy),
        .o_frame_cnt   (fcnt),
        .o_err         (err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        tdata  = d;
        tkeep  = k;
        tlast  = l;
        tvalid = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({tready, wr, busy, err, fcnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL reset: got tready/wr/busy/err/cnt=%b%b%b%b/%0d want 1000/0", tready, wr, busy, err, fcnt);
        end
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [8:0] exp [4] = '{9'h011, 9'h022, 9'h033, 9'h144};
        beat(32'h44332211, 4'hF, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (tready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: got %b want 1", tready);
        end
        cyc();
        tvalid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            n_cmp++;
            if ({wr, wdata} !== {1'b1, exp[b]}) begin
                n_fail++;
                $display("FAIL single_byte%0d: got wr=%b data=%h want wr=1 data=%h", b, wr, wdata, exp[b]);
            end
            cyc();
        end
        n_cmp++;
        if ({busy, fcnt} !== {1'b0, 16'd1}) begin
            n_fail++;
            $display("FAIL single_end: got busy=%b cnt=%0d want busy=0 cnt=1", busy, fcnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp [5] = '{9'h0AA, 9'h0BB, 9'h0CC, 9'h0DD, 9'h199};
        beat(32'hDDCCBBAA, 4'hF, 1'b0);
        cyc();
        beat(32'h00000099, 4'h1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({wr, wdata, tready} !== {1'b1, exp[i], i >= 3}) begin
                n_fail++;
                $display("FAIL b2b_byte%0d: got wr=%b data=%h rdy=%b want wr=1 data=%h rdy=%b",
                         i, wr, wdata, tready, exp[i], i >= 3);
            end
            cyc();
            if (i == 3) tvalid = 1'b0;
        end
        n_cmp++;
        if ({busy, fcnt} !== {1'b0, 16'd2}) begin
            n_fail++;
            $display("FAIL b2b_end: got busy=%b cnt=%0d want busy=0 cnt=2", busy, fcnt);
        end
    endtask

    task automatic test_sparse();
        logic [8:0] exp [2] = '{9'h022, 9'h144};
        beat(32'h44332211, 4'hA, 1'b1);
        cyc();
        tvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({wr, wdata} !== {1'b1, exp[i]}) begin
                n_fail++;
                $display("FAIL sparse_byte%0d: got wr=%b data=%h want wr=1 data=%h", i, wr, wdata, exp[i]);
            end
            cyc();
        end
        @(negedge clk);
        n_cmp++;
        if ({wr, busy, fcnt} !== {1'b0, 1'b0, 16'd3}) begin
            n_fail++;
            $display("FAIL sparse_end: got wr=%b busy=%b cnt=%0d want 0/0/3", wr, busy, fcnt);
        end
    endtask

    task automatic test_full();
        logic [8:0] exp [3] = '{9'h022, 9'h033, 9'h144};
        beat(32'h44332211, 4'hF, 1'b1);
        cyc();
        tvalid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({wr, wdata} !== {1'b1, 9'h011}) begin
            n_fail++;
            $display("FAIL full_byte0: got wr=%b data=%h want wr=1 data=011", wr, wdata);
        end
        cyc();
        wfull = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({wr, tready, wdata} !== {1'b0, 1'b0, 9'h022}) begin
                n_fail++;
                $display("FAIL full_stall%0d: got wr=%b rdy=%b data=%h want wr=0 rdy=0 data=022", i, wr, tready, wdata);
            end
            cyc();
        end
        wfull = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({wr, wdata} !== {1'b1, exp[i]}) begin
                n_fail++;
                $display("FAIL full_resume%0d: got wr=%b data=%h want wr=1 data=%h", i, wr, wdata, exp[i]);
            end
            cyc();
        end
        n_cmp++;
        if ({busy, fcnt} !== {1'b0, 16'd4}) begin
            n_fail++;
            $display("FAIL full_end: got busy=%b cnt=%0d want busy=0 cnt=4", busy, fcnt);
        end
    endtask

    task automatic test_empty_last();
        beat(32'h0, 4'h0, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (tready !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_ready: got %b want 1", tready);
        end
        cyc();
        tvalid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({wr, busy, err, fcnt} !== {1'b0, 1'b0, 1'b1, 16'd4}) begin
            n_fail++;
            $display("FAIL empty_after: got wr=%b busy=%b err=%b cnt=%0d want 0/0/1/4", wr, busy, err, fcnt);
        end
        beat(32'h00000055, 4'h1, 1'b1);
        cyc();
        tvalid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({wr, wdata} !== {1'b1, 9'h155}) begin
            n_fail++;
            $display("FAIL empty_next: got wr=%b data=%h want wr=1 data=155", wr, wdata);
        end
        cyc();
        @(negedge clk);
        n_cmp++;
        if ({err, fcnt} !== {1'b1, 16'd5}) begin
            n_fail++;
            $display("FAIL err_sticky: got err=%b cnt=%0d want err=1 cnt=5", err, fcnt);
        end
    endtask

    task automatic test_mid_reset();
        logic [8:0] exp [2] = '{9'h055, 9'h166};
        beat(32'h44332211, 4'hF, 1'b1);
        cyc();
        tvalid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({wr, wdata} !== {1'b1, 9'h011}) begin
            n_fail++;
            $display("FAIL mrst_byte0: got wr=%b data=%h want wr=1 data=011", wr, wdata);
        end
        cyc();
        @(negedge clk);
        n_cmp++;
        if ({wr, wdata} !== {1'b1, 9'h022}) begin
            n_fail++;
            $display("FAIL mrst_byte1: got wr=%b data=%h want wr=1 data=022", wr, wdata);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({tready, wr, busy, err, fcnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL mrst_async: got tready/wr/busy/err/cnt=%b%b%b%b/%0d want 1000/0", tready, wr, busy, err, fcnt);
        end
        cyc();
        rst_n = 1'b1;
        beat(32'h88776655, 4'h3, 1'b1);
        cyc();
        tvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({wr, wdata} !== {1'b1, exp[i]}) begin
                n_fail++;
                $display("FAIL mrst_after%0d: got wr=%b data=%h want wr=1 data=%h", i, wr, wdata, exp[i]);
            end
            cyc();
        end
        n_cmp++;
        if ({busy, fcnt} !== {1'b0, 16'd1}) begin
            n_fail++;
            $display("FAIL mrst_end: got busy=%b cnt=%0d want busy=0 cnt=1", busy, fcnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_sparse();
        test_full();
        test_empty_last();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
